// File: rtl/vga_pkg.sv
// Shared types, defaults and the fixed tile palette for the VGA tile renderer.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int V_ACTIVE_DEF = 480;

  typedef enum logic [3:0] {
    BLACK   = 4'd0,
    WHITE   = 4'd1,
    COLGRAD = 4'd2,
    ROWGRAD = 4'd3,
    GREEN   = 4'd4,
    RED     = 4'd5,
    BLUE    = 4'd6,
    YELLOW  = 4'd7
  } tile_code_t;

  // Per-pixel context carried down the pipeline until the decode stage.
  typedef struct packed {
    logic [2:0] col_lo;
    logic [2:0] row_lo;
    logic       active;
    logic       synced;
    logic       px0;
    logic       ln0;
    logic       hs;
    logic       vs;
    logic       last;
  } pix_t;

  // Returns one enable bit per channel {R,G,B}; the caller widens to RGB_W.
  function automatic logic [2:0] palette(input logic [31:0] code,
                                         input logic [2:0]  col_lo,
                                         input logic [2:0]  row_lo);
    case (code)
      32'(BLACK):   palette = 3'b000;
      32'(WHITE):   palette = 3'b111;
      32'(COLGRAD): palette = col_lo;
      32'(ROWGRAD): palette = row_lo;
      32'(GREEN):   palette = 3'b010;
      32'(RED):     palette = 3'b100;
      32'(BLUE):    palette = 3'b001;
      32'(YELLOW):  palette = 3'b110;
      default:      palette = 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/tile_pos_counter.sv
// Position-within-tile and tile-index counter; outputs the updated value for the current cycle.
module tile_pos_counter #(
  parameter int TILE  = 20,
  parameter int IDX_W = 10,
  localparam int POS_W = (TILE > 1) ? $clog2(TILE) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  output logic [POS_W-1:0] pos,
  output logic [IDX_W-1:0] idx
);

  logic [POS_W-1:0] pos_q, pos_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  // Clear has priority; a step wraps the in-tile position and bumps the tile index.
  always_comb begin
    pos_d = pos_q;
    idx_d = idx_q;
    if (clear) begin
      pos_d = '0;
      idx_d = '0;
    end else if (step) begin
      if (pos_q == POS_W'(TILE - 1)) begin
        pos_d = '0;
        idx_d = idx_q + IDX_W'(1);
      end else begin
        pos_d = pos_q + POS_W'(1);
      end
    end else begin
      pos_d = pos_q;
    end
  end

  // Counter state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      pos_q <= '0;
      idx_q <= '0;
    end else begin
      pos_q <= pos_d;
      idx_q <= idx_d;
    end
  end

  assign pos = pos_d;
  assign idx = idx_d;

endmodule

// File: rtl/vga_tile_renderer.sv
// Tile-based VGA pixel renderer: tracks tile coordinates, fetches one code per tile,
// decodes through a fixed palette and delays syncs to match the pixel latency MEM_LAT+2.
module vga_tile_renderer
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int TILE_W   = 20,
  parameter int TILE_H   = 20,
  parameter int CODE_W   = 4,
  parameter int RGB_W    = 1,
  parameter int MEM_LAT  = 1,
  parameter int ADDR_W   = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [9:0]        col,
  input  logic [9:0]        row,
  input  logic              active,
  input  logic              hsync_in,
  input  logic              vsync_in,
  input  logic              grid_en,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [CODE_W-1:0] mem_data,
  output logic [RGB_W-1:0]  R,
  output logic [RGB_W-1:0]  G,
  output logic [RGB_W-1:0]  B,
  output logic              hsync_out,
  output logic              vsync_out,
  output logic              frame_done
);

  localparam int D       = MEM_LAT + 1;          // pixel stages ahead of the output register
  localparam int TILES_X = H_ACTIVE / TILE_W;
  localparam int PX_W    = (TILE_W > 1) ? $clog2(TILE_W) : 1;
  localparam int LN_W    = (TILE_H > 1) ? $clog2(TILE_H) : 1;

  logic [PX_W-1:0]   px_s;
  logic [LN_W-1:0]   ln_s;
  logic [ADDR_W-1:0] tile_x_s, tile_y_s;
  logic              col_zero_s, origin_s, ln_step_s;

  logic              line_act_q, line_act_d;
  logic              synced_q, synced_d;
  logic              mem_re_q, mem_re_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [MEM_LAT-1:0] stb_q, stb_d;
  logic [CODE_W-1:0] code_q, code_d;
  pix_t              cur_s, out_s;
  pix_t              pipe_q [D];
  pix_t              pipe_d [D];
  logic [2:0]        rgb_s;
  logic [RGB_W-1:0]  r_q, r_d, g_q, g_d, b_q, b_d;
  logic              hs_q, hs_d, vs_q, vs_d, fd_q, fd_d;

  assign col_zero_s = (col == 10'd0);
  assign origin_s   = col_zero_s && (row == 10'd0);
  assign ln_step_s  = col_zero_s && (row != 10'd0) && line_act_q;

  tile_pos_counter #(.TILE(TILE_W), .IDX_W(ADDR_W)) u_x_cnt (
    .clk(clk), .reset(reset), .clear(col_zero_s), .step(active),
    .pos(px_s), .idx(tile_x_s)
  );

  tile_pos_counter #(.TILE(TILE_H), .IDX_W(ADDR_W)) u_y_cnt (
    .clk(clk), .reset(reset), .clear(origin_s), .step(ln_step_s),
    .pos(ln_s), .idx(tile_y_s)
  );

  // Front end: line activity, frame sync, fetch request and the per-pixel context.
  always_comb begin
    if (col_zero_s) begin
      line_act_d = active;
    end else begin
      line_act_d = line_act_q | active;
    end
    synced_d     = synced_q | origin_s;
    mem_re_d     = active && (px_s == PX_W'(0)) && synced_d;
    mem_addr_d   = ADDR_W'(32'(tile_y_s) * 32'(TILES_X) + 32'(tile_x_s));
    cur_s.col_lo = col[2:0];
    cur_s.row_lo = row[2:0];
    cur_s.active = active;
    cur_s.synced = synced_d;
    cur_s.px0    = (px_s == PX_W'(0));
    cur_s.ln0    = (ln_s == LN_W'(0));
    cur_s.hs     = hsync_in;
    cur_s.vs     = vsync_in;
    cur_s.last   = active && (col == 10'(H_ACTIVE - 1)) && (row == 10'(V_ACTIVE - 1));
  end

  // Delay lines: pixel context D deep, capture strobe MEM_LAT deep behind mem_re.
  always_comb begin
    pipe_d[0] = cur_s;
    for (int i = 1; i < D; i++) begin
      pipe_d[i] = pipe_q[i-1];
    end
    stb_d[0] = mem_re_q;
    for (int i = 1; i < MEM_LAT; i++) begin
      stb_d[i] = stb_q[i-1];
    end
  end

  // Decode stage: the strobe cycle uses mem_data directly so a tile's first pixel is on time.
  always_comb begin
    out_s = pipe_q[D-1];
    if (stb_q[MEM_LAT-1]) begin
      code_d = mem_data;
    end else begin
      code_d = code_q;
    end
    if (!out_s.active || !out_s.synced) begin
      rgb_s = 3'b000;
    end else if (grid_en && (out_s.px0 || out_s.ln0)) begin
      rgb_s = 3'b111;
    end else begin
      rgb_s = palette(32'(code_d), out_s.col_lo, out_s.row_lo);
    end
    r_d  = {RGB_W{rgb_s[2]}};
    g_d  = {RGB_W{rgb_s[1]}};
    b_d  = {RGB_W{rgb_s[0]}};
    hs_d = out_s.hs;
    vs_d = out_s.vs;
    fd_d = out_s.last;
  end

  // All pipeline and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      line_act_q <= 1'b0;
      synced_q   <= 1'b0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      stb_q      <= '0;
      code_q     <= '0;
      for (int i = 0; i < D; i++) begin
        pipe_q[i] <= '0;
      end
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= 1'b0;
      vs_q <= 1'b0;
      fd_q <= 1'b0;
    end else begin
      line_act_q <= line_act_d;
      synced_q   <= synced_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      stb_q      <= stb_d;
      code_q     <= code_d;
      for (int i = 0; i < D; i++) begin
        pipe_q[i] <= pipe_d[i];
      end
      r_q  <= r_d;
      g_q  <= g_d;
      b_q  <= b_d;
      hs_q <= hs_d;
      vs_q <= vs_d;
      fd_q <= fd_d;
    end
  end

  assign mem_re     = mem_re_q;
  assign mem_addr   = mem_addr_q;
  assign R          = r_q;
  assign G          = g_q;
  assign B          = b_q;
  assign hsync_out  = hs_q;
  assign vsync_out  = vs_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_vga_tile_renderer.sv
// Scoreboard bench for vga_tile_renderer on a reduced 90x60 raster with a partial last tile.
module tb_vga_tile_renderer;

  localparam int HA = 90, VA = 60, TW = 20, TH = 20, CW = 4, RW = 2, ML = 1, AW = 10;
  localparam int L = ML + 2, HT = 100, VT = 65, TX = HA / TW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [9:0]    col = 10'd0, row = 10'd0;
  logic          active = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, grid_en = 1'b0;
  logic          mem_re;
  logic [AW-1:0] mem_addr;
  logic [CW-1:0] mem_data;
  logic [RW-1:0] R, G, B;
  logic          hsync_out, vsync_out, frame_done;

  vga_tile_renderer #(.H_ACTIVE(HA), .V_ACTIVE(VA), .TILE_W(TW), .TILE_H(TH), .CODE_W(CW),
                      .RGB_W(RW), .MEM_LAT(ML), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .col(col), .row(row), .active(active),
    .hsync_in(hsync_in), .vsync_in(vsync_in), .grid_en(grid_en),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_data(mem_data),
    .R(R), .G(G), .B(B), .hsync_out(hsync_out), .vsync_out(vsync_out), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Game-state memory: one-cycle read latency, garbage on the bus when not read.
  logic [CW-1:0] mem [0:1023];
  logic [CW-1:0] junk = '0;
  bit            junk_fixed = 1'b0;
  always @(posedge clk) mem_data <= mem_re ? mem[mem_addr] : junk;

  typedef struct packed {
    logic [RW-1:0] r, g, b;
    logic          hs, vs, fd;
  } exp_t;

  exp_t          q[$];
  int            tagq[$];
  logic [AW:0]   mq[$];
  int            checks = 0, failures = 0;
  bit            synced_m = 1'b0;
  int            cnt_white, cnt_red, cnt_nonblack, cnt_re, cnt_fd;

  function automatic logic [2:0] ref_palette(input int code, input logic [9:0] c, input logic [9:0] r);
    case (code)
      1: ref_palette = 3'b111;
      2: ref_palette = {c[2], c[1], c[0]};
      3: ref_palette = {r[2], r[1], r[0]};
      4: ref_palette = 3'b010;
      5: ref_palette = 3'b100;
      6: ref_palette = 3'b001;
      7: ref_palette = 3'b110;
      default: ref_palette = 3'b000;
    endcase
  endfunction

  task automatic clear_counts();
    cnt_white = 0; cnt_red = 0; cnt_nonblack = 0; cnt_re = 0; cnt_fd = 0;
  endtask

  // One pixel clock: compare what is due, then drive the next pixel and queue its expectation.
  task automatic step(input int c, input int r, input logic rst);
    exp_t        e, got;
    logic [AW:0] me, mg;
    logic        act, hs, vs;
    logic [2:0]  p;
    int          tag;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e   = q.pop_front();
      tag = tagq.pop_front();
      got = {R, G, B, hsync_out, vsync_out, frame_done};
      checks++;
      if (got !== e) begin
        failures++;
        $display("FAIL pixel tag=%0d got=%h exp=%h", tag, got, e);
      end
      if (got.r == {RW{1'b1}} && got.g == {RW{1'b1}} && got.b == {RW{1'b1}}) cnt_white++;
      if (got.r == {RW{1'b1}} && got.g == '0 && got.b == '0) cnt_red++;
      if ((got.r | got.g | got.b) != '0) cnt_nonblack++;
      if (got.fd) cnt_fd++;
    end
    if (mq.size() > 0) begin
      me = mq.pop_front();
      mg = {mem_re, mem_re ? mem_addr : AW'(0)};
      checks++;
      if (mg !== me) begin
        failures++;
        $display("FAIL fetch got=%h exp=%h", mg, me);
      end
      if (mem_re === 1'b1) cnt_re++;
    end
    if (!junk_fixed) junk = CW'($urandom);
    act = (c < HA) && (r < VA);
    hs  = (c >= 92) && (c < 96);
    vs  = (r >= 61) && (r < 63);
    col = 10'(c); row = 10'(r); active = act; hsync_in = hs; vsync_in = vs; reset = rst;
    if (rst) begin
      synced_m = 1'b0;
      q.delete(); tagq.delete(); mq.delete();
      for (int i = 0; i < L; i++) begin
        q.push_back('0);
        tagq.push_back(-1);
      end
      mq.push_back('0);
    end else begin
      if (c == 0 && r == 0) synced_m = 1'b1;
      if (!act || !synced_m) p = 3'b000;
      else if (grid_en && (c % TW == 0 || r % TH == 0)) p = 3'b111;
      else p = ref_palette(int'(mem[(r / TH) * TX + c / TW]), col, row);
      e = {{RW{p[2]}}, {RW{p[1]}}, {RW{p[0]}}, hs, vs, act && c == HA - 1 && r == VA - 1};
      q.push_back(e);
      tagq.push_back(r * 1000 + c);
      if (act && synced_m && (c % TW == 0)) me = {1'b1, AW'((r / TH) * TX + c / TW)};
      else me = '0;
      mq.push_back(me);
    end
  endtask

  task automatic run_frame();
    for (int r = 0; r < VT; r++)
      for (int c = 0; c < HT; c++)
        step(c, r, 1'b0);
  endtask

  task automatic fill_mem(input int v);
    for (int i = 0; i < 1024; i++) mem[i] = CW'(v);
  endtask

  task automatic test_reset();
    fill_mem(1);
    junk_fixed = 1'b1; junk = CW'(1);
    grid_en = 1'b0;
    clear_counts();
    for (int c = 30; c < 35; c++) step(c, 10, 1'b1);
    for (int c = 35; c < HT; c++) step(c, 10, 1'b0);
    for (int r = 11; r < VT; r++)
      for (int c = 0; c < HT; c++)
        step(c, r, 1'b0);
    checks++;
    if (cnt_nonblack != 0) begin
      failures++;
      $display("FAIL unsynced_rgb got=%0d exp=0", cnt_nonblack);
    end
    checks++;
    if (cnt_re != 0) begin
      failures++;
      $display("FAIL unsynced_mem_re got=%0d exp=0", cnt_re);
    end
    junk_fixed = 1'b0;
  endtask

  task automatic test_white_tile();
    fill_mem(0); mem[0] = CW'(1);
    clear_counts();
    run_frame();
    checks++;
    if (cnt_white != TW * TH) begin
      failures++;
      $display("FAIL white_count got=%0d exp=%0d", cnt_white, TW * TH);
    end
    checks++;
    if (cnt_re != 5 * VA) begin
      failures++;
      $display("FAIL mem_re_count got=%0d exp=%0d", cnt_re, 5 * VA);
    end
  endtask

  task automatic test_red_tile();
    fill_mem(0); mem[TX + 1] = CW'(5);
    clear_counts();
    run_frame();
    checks++;
    if (cnt_red != TW * TH) begin
      failures++;
      $display("FAIL red_count got=%0d exp=%0d", cnt_red, TW * TH);
    end
    checks++;
    if (cnt_nonblack != TW * TH) begin
      failures++;
      $display("FAIL red_other_tiles got=%0d exp=%0d", cnt_nonblack, TW * TH);
    end
  endtask

  task automatic test_grid();
    fill_mem(0);
    grid_en = 1'b1;
    clear_counts();
    run_frame();
    grid_en = 1'b0;
    checks++;
    if (cnt_white != 555 || cnt_nonblack != 555) begin
      failures++;
      $display("FAIL grid_count got=%0d/%0d exp=555", cnt_white, cnt_nonblack);
    end
  endtask

  task automatic test_colgrad();
    fill_mem(2);
    clear_counts();
    run_frame();
    checks++;
    if (cnt_nonblack != 78 * VA) begin
      failures++;
      $display("FAIL colgrad_nonblack got=%0d exp=%0d", cnt_nonblack, 78 * VA);
    end
    checks++;
    if (cnt_white != 11 * VA) begin
      failures++;
      $display("FAIL colgrad_white got=%0d exp=%0d", cnt_white, 11 * VA);
    end
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 1024; i++) mem[i] = CW'($urandom);
      grid_en = (f == 1);
      clear_counts();
      run_frame();
      checks++;
      if (cnt_fd != 1) begin
        failures++;
        $display("FAIL frame_done_count got=%0d exp=1", cnt_fd);
      end
    end
    grid_en = 1'b0;
  endtask

  initial begin
    fill_mem(0);
    test_reset();
    test_white_tile();
    test_red_tile();
    test_grid();
    test_colgrad();
    test_back_to_back();
    for (int i = 0; i < L + 1; i++) step(0, 64, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
